// File: rtl/fsm_run_counter.sv
`default_nettype none
// ============================================================================
// Module      : fsm_run_counter
// Description : Run/done sequencing FSM. An accepted i_run starts a RUN phase
//               of N cycles (N latched from i_num_cnt), followed by a single
//               DONE cycle. Supports abort, a zero-count error pulse, Moore
//               status outputs and an optional auto-reload loop.
// Ports       : clk        - clock, all state updates on posedge
//               reset      - asynchronous active-high reset
//               i_run      - start request, sampled only in IDLE
//               i_num_cnt  - run length N, latched when i_run is accepted
//               i_abort    - cancel RUN/DONE, return to IDLE
//               o_idle     - state is IDLE
//               o_running  - state is RUN
//               o_done     - state is DONE (one cycle per completed run)
//               o_err      - one-cycle pulse after i_run accepted with N == 0
//               o_cnt_val  - current run counter value
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_run_counter #(
    parameter int CNT_WIDTH   = 7,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
    input  logic                 i_abort,
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_cnt_val
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [CNT_WIDTH-1:0] num_q,   num_d;
    logic                 err_q,   err_d;

    // Last RUN cycle is the one where the counter shows N-1; N is never zero
    // inside RUN, so the subtraction cannot underflow there.
    logic                 w_last;
    assign w_last = (cnt_q == (num_q - C_ONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= C_ZERO;
            num_q   <= C_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = C_ZERO;
                // Abort has priority over a simultaneous start request.
                if (!i_abort && i_run) begin
                    if (i_num_cnt != C_ZERO) begin
                        state_d = RUN;
                        num_d   = i_num_cnt;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_d = IDLE;
                    cnt_d   = C_ZERO;
                end else if (w_last) begin
                    // Counter holds N-1 through the DONE cycle.
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + C_ONE;
                end
            end
            DONE: begin
                cnt_d = C_ZERO;
                if (!i_abort && AUTO_RELOAD) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = C_ZERO;
            end
        endcase
    end

    assign o_idle    = (state_q == IDLE);
    assign o_running = (state_q == RUN);
    assign o_done    = (state_q == DONE);
    assign o_err     = err_q;
    assign o_cnt_val = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_run_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_run_counter
// Description : Self-checking bench for fsm_run_counter. Two instances (plain
//               and auto-reload) share stimulus; each is compared every cycle
//               against a run-position model of the expected behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_run_counter;

    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_run = 1'b0;
    logic [CW-1:0] i_num_cnt = '0;
    logic          i_abort = 1'b0;

    logic          idle0, run0, done0, err0;
    logic [CW-1:0] cnt0;
    logic          idle1, run1, done1, err1;
    logic [CW-1:0] cnt1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fsm_run_counter #(.CNT_WIDTH(CW), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_abort(i_abort), .o_idle(idle0), .o_running(run0), .o_done(done0),
        .o_err(err0), .o_cnt_val(cnt0)
    );

    fsm_run_counter #(.CNT_WIDTH(CW), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_abort(i_abort), .o_idle(idle1), .o_running(run1), .o_done(done1),
        .o_err(err1), .o_cnt_val(cnt1)
    );

    // {idle, running, done, err, cnt}
    logic [CW+3:0] obs [0:1];
    always_comb begin
        obs[0] = {idle0, run0, done0, err0, cnt0};
        obs[1] = {idle1, run1, done1, err1, cnt1};
    end

    // Model: a run is "active" from acceptance; pos counts cycles into it.
    // pos 0..n-1 are RUN cycles, pos == n is the DONE cycle.
    bit m_act [0:1];
    int m_pos [0:1];
    int m_n   [0:1];
    bit m_err [0:1];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_pos[i] = 0; m_n[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(int i);
        bit e;
        e = 0;
        if (!m_act[i]) begin
            if (!i_abort && i_run) begin
                if (i_num_cnt != 0) begin
                    m_act[i] = 1; m_pos[i] = 0; m_n[i] = int'(i_num_cnt);
                end else begin
                    e = 1;
                end
            end
        end else if (i_abort) begin
            m_act[i] = 0;
        end else begin
            m_pos[i]++;
            if (m_pos[i] > m_n[i]) begin
                if (i == 1) m_pos[i] = 0;
                else        m_act[i] = 0;
            end
        end
        m_err[i] = e;
    endtask

    function automatic logic [CW+3:0] expect_of(int i);
        logic [CW-1:0] c;
        bit            r, d;
        r = m_act[i] && (m_pos[i] < m_n[i]);
        d = m_act[i] && (m_pos[i] == m_n[i]);
        if (r)      c = CW'(m_pos[i]);
        else if (d) c = CW'(m_n[i] - 1);
        else        c = '0;
        return {!m_act[i], r, d, m_err[i], c};
    endfunction

    // One clock: model advances on the edge, outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_num_cnt = 7'd20; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        repeat (4) tick();
        #1 reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (obs[i] !== expect_of(i)) begin
                mismatched++;
                $display("FAIL reset_async inst%0d got %b want %b", i, obs[i], expect_of(i));
            end
        end
        #9 reset = 1'b0;
        repeat (2) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL reset_release inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
        end
    endtask

    task automatic test_basic();
        i_num_cnt = 7'd5; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        repeat (8) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL basic inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
        end
        i_abort = 1'b1; tick(); i_abort = 1'b0;
    endtask

    task automatic test_zero();
        i_num_cnt = 7'd0; i_run = 1'b1;
        tick();
        i_run = 1'b0; i_num_cnt = 7'd9;
        repeat (3) begin
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL zero_cnt inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
            tick();
        end
    endtask

    task automatic test_abort();
        i_num_cnt = 7'd10; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        repeat (3) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        for (int n = 0; n < 14; n++) begin
            // Simultaneous run + abort in IDLE must not start a run.
            if (n == 3) begin i_run = 1'b1; i_abort = 1'b1; end
            if (n == 4) begin i_run = 1'b0; i_abort = 1'b0; end
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL abort inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
            tick();
        end
    endtask

    task automatic test_max();
        i_num_cnt = 7'd127; i_run = 1'b1;
        repeat (136) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL max_run inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
        end
        i_run = 1'b0; i_abort = 1'b1; tick(); i_abort = 1'b0;
    endtask

    task automatic test_reload();
        i_num_cnt = 7'd3; i_run = 1'b1;
        tick();
        i_run = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (n == 5) i_num_cnt = 7'd6;
            if (n == 14) i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL reload inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_run     = ($urandom_range(3) == 0);
            i_abort   = ($urandom_range(19) == 0);
            i_num_cnt = ($urandom_range(9) == 0) ? CW'($urandom) : CW'($urandom_range(4));
            tick();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obs[i] !== expect_of(i)) begin
                    mismatched++;
                    $display("FAIL random inst%0d got %b want %b", i, obs[i], expect_of(i));
                end
            end
        end
        i_run = 1'b0; i_abort = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (obs[i] !== expect_of(i)) begin
                mismatched++;
                $display("FAIL initial_reset inst%0d got %b want %b", i, obs[i], expect_of(i));
            end
        end
        reset = 1'b0;
        tick();
        test_basic();
        test_zero();
        test_abort();
        test_max();
        test_reload();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
